minmax_tree_pipe: RTL and testbench

//  Parametrised, pipelined min/max selector; next generation of the registered 2-input min stage.

---
 rtl/minmax_pkg.sv | 53 +++++
 rtl/minmax_cmp_sel.sv | 57 +++++
 rtl/minmax_tree_pipe.sv | 143 ++++++++++++++
 tb/tb_minmax_tree_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared definitions for the min/max selector family.
//
// Contents:
//   mode_e    - MODE_MIN (select smaller) / MODE_MAX (select larger)
//   CMP_W     - internal comparison width; operands up to CMP_W bits are supported
//   align     - left-justifies an operand into CMP_W bits
//   better    - strict "a beats b" test for a given mode and signedness
//   num_nodes - number of tree nodes at a given level of a reduction tree
package minmax_pkg;

    typedef enum logic {
        MODE_MIN = 1'b0,
        MODE_MAX = 1'b1
    } mode_e;

    localparam int CMP_W = 64;

    // Left-justifying keeps the sign bit of the operand in the MSB of the
    // CMP_W-bit value. Both signed and unsigned ordering are unchanged by the
    // shift, so one compare routine serves every operand width.
    function automatic logic [CMP_W-1:0] align(input logic [CMP_W-1:0] v, input int width);
        return v << (CMP_W - width);
    endfunction

    // Strictly better: equal operands never win. Callers rely on this so that
    // ties keep the lower lane index.
    function automatic logic better(input logic [CMP_W-1:0] a,
                                    input logic [CMP_W-1:0] b,
                                    input logic             mode,
                                    input logic             is_signed);
        logic a_lt_b;
        logic b_lt_a;
        if (is_signed) begin
            a_lt_b = $signed(a) < $signed(b);
            b_lt_a = $signed(b) < $signed(a);
        end else begin
            a_lt_b = a < b;
            b_lt_a = b < a;
        end
        return (mode == MODE_MAX) ? b_lt_a : a_lt_b;
    endfunction

    // Each level halves the node count, rounding up; the odd node passes through.
    function automatic int num_nodes(input int n, input int level);
        int c;
        c = n;
        for (int k = 0; k < level; k++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

endpackage

// File: rtl/minmax_cmp_sel.sv
// Registered 2-input compare-select node of the min/max tree.
//
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   en                  pipeline advance; all state holds when low
//   in_valid, in_mode   valid and mode of the vector at this node
//   a_data, a_idx       lower-lane operand and its lane index
//   b_data, b_idx       higher-lane operand (tie a_* to b_* for pass-through)
//   out_valid, out_mode registered valid / mode
//   out_data, out_idx   registered winner and its lane index
module minmax_cmp_sel
    import minmax_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IDX_W  = 2,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] a_data,
    input  logic [IDX_W-1:0] a_idx,
    input  logic [WIDTH-1:0] b_data,
    input  logic [IDX_W-1:0] b_idx,
    output logic             out_valid,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx
);

    logic take_b;

    // The higher lane wins only when strictly better, so ties go to lane a.
    // A pass-through node feeds a into both sides and therefore always keeps a.
    always_comb begin
        take_b = better(align(CMP_W'(b_data), WIDTH),
                        align(CMP_W'(a_data), WIDTH),
                        in_mode, SIGNED != 0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            out_data  <= take_b ? b_data : a_data;
            out_idx   <= take_b ? b_idx  : a_idx;
        end
    end

endmodule

// File: rtl/minmax_tree_pipe.sv
// Pipelined min/max selector: reduces NUM_IN operands per vector to one
// extremum plus its lane index through a registered compare tree, and keeps a
// running extremum across results until cleared.
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   in_valid, in_ready    input handshake
//   in_data               NUM_IN lanes, lane k at [k*WIDTH +: WIDTH]
//   in_mode               0 = min, 1 = max, travels with the vector
//   run_clr               clears the running extremum
//   out_valid, out_ready  output handshake
//   out_data, out_idx     extremum and its lane index
//   out_mode              mode the result was computed with
//   run_valid, run_data   running extremum since last clear / reset
module minmax_tree_pipe
    import minmax_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_IN = 4,
    parameter  int SIGNED = 0,
    localparam int IDX_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_mode,
    input  logic                    run_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_mode,
    output logic                    run_valid,
    output logic [WIDTH-1:0]        run_data
);

    localparam int LEVELS = IDX_W;

    // Node state per tree level; level 0 is the unregistered input vector.
    logic [WIDTH-1:0] node_data  [LEVELS+1][NUM_IN];
    logic [IDX_W-1:0] node_idx   [LEVELS+1][NUM_IN];
    logic             node_mode  [LEVELS+1][NUM_IN];
    logic             node_valid [LEVELS+1][NUM_IN];

    logic advance;
    logic hs;
    logic take;
    logic run_mode;

    // The whole tree moves together: it advances whenever the output stage is
    // empty or being drained, which also gives one vector per cycle.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    generate
        for (genvar j = 0; j < NUM_IN; j++) begin : g_lane
            assign node_data[0][j]  = in_data[j*WIDTH +: WIDTH];
            assign node_idx[0][j]   = IDX_W'(j);
            assign node_mode[0][j]  = in_mode;
            assign node_valid[0][j] = in_valid;
        end

        for (genvar l = 1; l <= LEVELS; l++) begin : g_level
            localparam int N_PREV = num_nodes(NUM_IN, l - 1);
            localparam int N_CUR  = num_nodes(NUM_IN, l);
            for (genvar j = 0; j < NUM_IN; j++) begin : g_node
                if (j < N_CUR) begin : g_cmp
                    // An unpaired last node compares with itself and passes through.
                    localparam int B = (2*j + 1 < N_PREV) ? 2*j + 1 : 2*j;
                    minmax_cmp_sel #(
                        .WIDTH  (WIDTH),
                        .IDX_W  (IDX_W),
                        .SIGNED (SIGNED)
                    ) u_cmp (
                        .clk       (clk),
                        .rst_n     (rst_n),
                        .en        (advance),
                        .in_valid  (node_valid[l-1][2*j]),
                        .in_mode   (node_mode[l-1][2*j]),
                        .a_data    (node_data[l-1][2*j]),
                        .a_idx     (node_idx[l-1][2*j]),
                        .b_data    (node_data[l-1][B]),
                        .b_idx     (node_idx[l-1][B]),
                        .out_valid (node_valid[l][j]),
                        .out_mode  (node_mode[l][j]),
                        .out_data  (node_data[l][j]),
                        .out_idx   (node_idx[l][j])
                    );
                end else begin : g_unused
                    assign node_data[l][j]  = '0;
                    assign node_idx[l][j]   = '0;
                    assign node_mode[l][j]  = 1'b0;
                    assign node_valid[l][j] = 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid = node_valid[LEVELS][0];
    assign out_data  = node_data[LEVELS][0];
    assign out_idx   = node_idx[LEVELS][0];
    assign out_mode  = node_mode[LEVELS][0];

    assign hs = out_valid & out_ready;

    // A handshaken result loads the running value when the tracker is empty,
    // was just cleared, or the mode changed; otherwise it replaces the running
    // value only when strictly better.
    always_comb begin
        take = 1'b0;
        if (hs) begin
            if (run_clr || !run_valid || (out_mode != run_mode)) begin
                take = 1'b1;
            end else begin
                take = better(align(CMP_W'(out_data), WIDTH),
                              align(CMP_W'(run_data), WIDTH),
                              out_mode, SIGNED != 0);
            end
        end
    end

    // Running tracker state; a clear coinciding with a handshake ends valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_valid <= 1'b0;
            run_data  <= '0;
            run_mode  <= 1'b0;
        end else begin
            if (take) begin
                run_data <= out_data;
            end
            if (hs) begin
                run_mode  <= out_mode;
                run_valid <= 1'b1;
            end else if (run_clr) begin
                run_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_minmax_tree_pipe.sv
// Self-checking bench for minmax_tree_pipe: a 4-lane unsigned instance and a
// 5-lane signed instance, checked against a linear-scan reference model.
module tb_minmax_tree_pipe;

    localparam int W = 8;

    typedef logic [7:0] vec_t [8];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid4, in_ready4, in_mode4, run_clr4;
    logic           out_valid4, out_ready4, out_mode4, run_valid4;
    logic [4*W-1:0] in_data4;
    logic [W-1:0]   out_data4, run_data4;
    logic [1:0]     out_idx4;

    logic           in_valid5, in_ready5, in_mode5, run_clr5;
    logic           out_valid5, out_ready5, out_mode5, run_valid5;
    logic [5*W-1:0] in_data5;
    logic [W-1:0]   out_data5, run_data5;
    logic [2:0]     out_idx5;

    int n_tests = 0;
    int n_fail  = 0;

    minmax_tree_pipe #(.WIDTH(W), .NUM_IN(4), .SIGNED(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_mode(in_mode4),
        .run_clr(run_clr4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_idx(out_idx4), .out_mode(out_mode4),
        .run_valid(run_valid4), .run_data(run_data4)
    );

    minmax_tree_pipe #(.WIDTH(W), .NUM_IN(5), .SIGNED(1)) u_dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5), .in_mode(in_mode5),
        .run_clr(run_clr5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
        .out_idx(out_idx5), .out_mode(out_mode5),
        .run_valid(run_valid5), .run_data(run_data5)
    );

    // Reference model: value of a lane as an integer, then a linear scan in
    // which only a strictly better lane replaces the current best.
    function automatic int to_int(input logic [7:0] x, input bit sgn);
        return sgn ? int'($signed(x)) : int'({24'd0, x});
    endfunction

    function automatic void ref_pick(input vec_t v, input int n, input logic mode, input bit sgn,
                                     output logic [7:0] d, output int idx);
        idx = 0;
        for (int k = 1; k < n; k++) begin
            if (mode ? (to_int(v[k], sgn) > to_int(v[idx], sgn))
                     : (to_int(v[k], sgn) < to_int(v[idx], sgn)))
                idx = k;
        end
        d = v[idx];
    endfunction

    function automatic int extremum(input int q[$], input logic mode);
        int r;
        r = q[0];
        foreach (q[k]) r = mode ? ((q[k] > r) ? q[k] : r) : ((q[k] < r) ? q[k] : r);
        return r;
    endfunction

    function automatic logic [4*W-1:0] pack4(input vec_t v);
        logic [4*W-1:0] p;
        for (int k = 0; k < 4; k++) p[k*W +: W] = v[k];
        return p;
    endfunction

    function automatic logic [5*W-1:0] pack5(input vec_t v);
        logic [5*W-1:0] p;
        for (int k = 0; k < 5; k++) p[k*W +: W] = v[k];
        return p;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        bit narrow;
        narrow = ($urandom_range(0, 1) == 1);
        for (int k = 0; k < 8; k++) v[k] = narrow ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic run_one4(input vec_t v, input logic mode, output logic [7:0] d,
                            output logic [1:0] idx, output logic m, output int lat);
        @(posedge clk); #1;
        in_data4 = pack4(v); in_mode4 = mode; in_valid4 = 1'b1; out_ready4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 1;
        while (out_valid4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = out_data4; idx = out_idx4; m = out_mode4;
    endtask

    task automatic run_one5(input vec_t v, input logic mode, output logic [7:0] d,
                            output logic [2:0] idx, output logic m, output int lat);
        @(posedge clk); #1;
        in_data5 = pack5(v); in_mode5 = mode; in_valid5 = 1'b1; out_ready5 = 1'b1;
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        lat = 1;
        while (out_valid5 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = out_data5; idx = out_idx5; m = out_mode5;
    endtask

    task automatic drain4();
        in_valid4 = 1'b0; out_ready4 = 1'b1; run_clr4 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        logic [7:0] d; logic [1:0] i; logic m; int lat; int seen; vec_t v;
        #2;
        n_tests++; if (out_valid4 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid4); end
        n_tests++; if (run_valid4 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_run_valid: got %b want 0", run_valid4); end
        n_tests++; if (out_valid5 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid5: got %b want 0", out_valid5); end
        @(negedge clk); rst_n = 1'b1;
        v = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00};
        run_one4(v, 1'b1, d, i, m, lat);
        n_tests++; if (d !== 8'h88 || i !== 2'd3) begin n_fail++; $display("[TB] FAIL pre_reset_result: got %h/%0d want 88/3", d, i); end
        @(posedge clk); #1;
        out_ready4 = 1'b0; in_valid4 = 1'b1; in_data4 = pack4(v); in_mode4 = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid4 !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_out_valid: got %b want 0", out_valid4); end
        n_tests++; if (run_valid4 !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_run_valid: got %b want 0", run_valid4); end
        n_tests++; if (out_data4 !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset_out_data: got %h want 00", out_data4); end
        n_tests++; if (out_idx4 !== 2'd0) begin n_fail++; $display("[TB] FAIL midreset_out_idx: got %0d want 0", out_idx4); end
        n_tests++; if (out_mode4 !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_out_mode: got %b want 0", out_mode4); end
        n_tests++; if (run_data4 !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset_run_data: got %h want 00", run_data4); end
        @(negedge clk);
        in_valid4 = 1'b0; out_ready4 = 1'b1; rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid4 !== 1'b0 || out_valid5 !== 1'b0) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("[TB] FAIL reset_discard: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_min_tie();
        logic [7:0] d; logic [1:0] i; logic m; int lat; vec_t v;
        v = '{8'd9, 8'd3, 8'd7, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
        run_one4(v, 1'b0, d, i, m, lat);
        n_tests++; if (d !== 8'd3) begin n_fail++; $display("[TB] FAIL min_tie_data: got %0d want 3", d); end
        n_tests++; if (i !== 2'd1) begin n_fail++; $display("[TB] FAIL min_tie_idx: got %0d want 1", i); end
        n_tests++; if (m !== 1'b0) begin n_fail++; $display("[TB] FAIL min_tie_mode: got %b want 0", m); end
        n_tests++; if (lat != 2) begin n_fail++; $display("[TB] FAIL min_tie_latency: got %0d want 2", lat); end
    endtask

    task automatic test_max_signed();
        logic [7:0] d; logic [1:0] i4; logic [2:0] i5; logic m; int lat; vec_t v;
        v = '{8'h10, 8'hF0, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
        run_one4(v, 1'b1, d, i4, m, lat);
        n_tests++; if (d !== 8'hF0 || i4 !== 2'd1) begin n_fail++; $display("[TB] FAIL max_unsigned: got %h/%0d want f0/1", d, i4); end
        n_tests++; if (m !== 1'b1) begin n_fail++; $display("[TB] FAIL max_unsigned_mode: got %b want 1", m); end
        run_one5(v, 1'b1, d, i5, m, lat);
        n_tests++; if (d !== 8'h7F || i5 !== 3'd3) begin n_fail++; $display("[TB] FAIL max_signed: got %h/%0d want 7f/3", d, i5); end
        run_one5(v, 1'b0, d, i5, m, lat);
        n_tests++; if (d !== 8'h80 || i5 !== 3'd2) begin n_fail++; $display("[TB] FAIL min_signed: got %h/%0d want 80/2", d, i5); end
    endtask

    task automatic test_odd_lane();
        logic [7:0] d, ed; logic [2:0] i; logic m, mode; int lat, ei; vec_t v;
        v = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0};
        run_one5(v, 1'b0, d, i, m, lat);
        n_tests++; if (d !== 8'd1 || i !== 3'd4) begin n_fail++; $display("[TB] FAIL odd_lane_min: got %0d/%0d want 1/4", d, i); end
        n_tests++; if (lat != 3) begin n_fail++; $display("[TB] FAIL odd_lane_latency: got %0d want 3", lat); end
        v = '{8'd1, 8'd4, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0};
        run_one5(v, 1'b0, d, i, m, lat);
        n_tests++; if (d !== 8'd1 || i !== 3'd0) begin n_fail++; $display("[TB] FAIL odd_lane_tie: got %0d/%0d want 1/0", d, i); end
        for (int t = 0; t < 20; t++) begin
            v = rand_vec();
            mode = 1'($urandom_range(0, 1));
            run_one5(v, mode, d, i, m, lat);
            ref_pick(v, 5, mode, 1'b1, ed, ei);
            n_tests++;
            if (d !== ed || i !== 3'(ei) || m !== mode || lat != 3) begin
                n_fail++;
                $display("[TB] FAIL random5_%0d: got %h/%0d/%b lat %0d want %h/%0d/%b lat 3", t, d, i, m, lat, ed, ei, mode);
            end
        end
    endtask

    task automatic test_back_to_back();
        int total, sent, got, cyc, ei;
        vec_t v; logic m; logic [7:0] ed;
        logic [7:0] exp_d[$]; int exp_i[$]; logic exp_m[$];
        int hist[$]; logic hist_mode;
        logic prev_stall; logic [7:0] prev_d; logic [1:0] prev_i; logic prev_m;
        logic [7:0] qd; int qi; logic qm;
        int late;
        total = 48; sent = 0; got = 0; cyc = 0;
        prev_stall = 1'b0; prev_d = '0; prev_i = '0; prev_m = 1'b0; hist_mode = 1'b0;
        drain4();
        run_clr4 = 1'b1; @(posedge clk); #1; run_clr4 = 1'b0;
        v = rand_vec(); m = 1'($urandom_range(0, 1));
        while (got < total && cyc < 600) begin
            in_valid4  = (sent < total) && (sent < 8 || $urandom_range(0, 3) != 0);
            in_data4   = pack4(v);
            in_mode4   = m;
            out_ready4 = (cyc < 8) ? !(cyc >= 3 && cyc <= 5) : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            n_tests++;
            if (run_valid4 !== (hist.size() > 0)) begin
                n_fail++; $display("[TB] FAIL run_valid_c%0d: got %b want %b", cyc, run_valid4, hist.size() > 0);
            end else if (hist.size() > 0 && run_data4 !== 8'(extremum(hist, hist_mode))) begin
                n_fail++; $display("[TB] FAIL run_data_c%0d: got %0d want %0d", cyc, run_data4, extremum(hist, hist_mode));
            end
            if (prev_stall) begin
                n_tests++;
                if (out_valid4 !== 1'b1 || out_data4 !== prev_d || out_idx4 !== prev_i || out_mode4 !== prev_m) begin
                    n_fail++; $display("[TB] FAIL hold_c%0d: got %b/%h/%0d want 1/%h/%0d", cyc, out_valid4, out_data4, out_idx4, prev_d, prev_i);
                end
            end
            if (out_valid4 === 1'b1 && !out_ready4) begin
                n_tests++;
                if (in_ready4 !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_ready_c%0d: got %b want 0", cyc, in_ready4); end
            end
            if (out_valid4 === 1'b1 && out_ready4) begin
                n_tests++;
                if (exp_d.size() == 0) begin
                    n_fail++; $display("[TB] FAIL dup_c%0d: got %h with nothing expected", cyc, out_data4);
                end else begin
                    qd = exp_d.pop_front(); qi = exp_i.pop_front(); qm = exp_m.pop_front();
                    if (out_data4 !== qd || out_idx4 !== 2'(qi) || out_mode4 !== qm) begin
                        n_fail++; $display("[TB] FAIL stream_%0d: got %h/%0d/%b want %h/%0d/%b", got, out_data4, out_idx4, out_mode4, qd, qi, qm);
                    end
                    if (hist.size() == 0 || qm != hist_mode) begin
                        hist.delete(); hist_mode = qm;
                    end
                    hist.push_back(int'({24'd0, qd}));
                end
                got++;
            end
            prev_stall = (out_valid4 === 1'b1) && !out_ready4;
            prev_d = out_data4; prev_i = out_idx4; prev_m = out_mode4;
            if (in_valid4 && in_ready4 === 1'b1) begin
                ref_pick(v, 4, m, 1'b0, ed, ei);
                exp_d.push_back(ed); exp_i.push_back(ei); exp_m.push_back(m);
                sent++;
                v = rand_vec(); m = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++; if (got != total) begin n_fail++; $display("[TB] FAIL stream_count: got %0d want %0d", got, total); end
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        late = 0;
        repeat (4) begin @(negedge clk); if (out_valid4 !== 1'b0) late++; end
        n_tests++; if (late != 0 || exp_d.size() != 0) begin n_fail++; $display("[TB] FAIL stream_tail: got %0d extra, %0d pending want 0/0", late, exp_d.size()); end
    endtask

    task automatic test_running();
        logic [7:0] d; logic [1:0] i; logic m; int lat, waited; vec_t v;
        drain4();
        run_clr4 = 1'b1; @(posedge clk); #1; run_clr4 = 1'b0;
        n_tests++; if (run_valid4 !== 1'b0) begin n_fail++; $display("[TB] FAIL run_clr_only: got %b want 0", run_valid4); end
        v = '{8'd6, 8'd9, 8'd200, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0};
        run_one4(v, 1'b0, d, i, m, lat); @(posedge clk); #1;
        n_tests++; if (run_valid4 !== 1'b1 || run_data4 !== 8'd6) begin n_fail++; $display("[TB] FAIL run_first: got %b/%0d want 1/6", run_valid4, run_data4); end
        v = '{8'd2, 8'd50, 8'd60, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
        run_one4(v, 1'b0, d, i, m, lat); @(posedge clk); #1;
        n_tests++; if (run_data4 !== 8'd2) begin n_fail++; $display("[TB] FAIL run_second: got %0d want 2", run_data4); end
        v = '{8'd9, 8'd5, 8'd8, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0};
        run_one4(v, 1'b0, d, i, m, lat); @(posedge clk); #1;
        n_tests++; if (run_data4 !== 8'd2) begin n_fail++; $display("[TB] FAIL run_third: got %0d want 2", run_data4); end
        v = '{8'd8, 8'd9, 8'd10, 8'd11, 8'd0, 8'd0, 8'd0, 8'd0};
        @(posedge clk); #1;
        in_data4 = pack4(v); in_mode4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
        @(posedge clk); #1;
        in_valid4 = 1'b0; waited = 0;
        while (out_valid4 !== 1'b1 && waited < 10) begin @(posedge clk); #1; waited++; end
        run_clr4 = 1'b1; out_ready4 = 1'b1;
        @(posedge clk); #1;
        run_clr4 = 1'b0;
        n_tests++; if (run_valid4 !== 1'b1 || run_data4 !== 8'd8) begin n_fail++; $display("[TB] FAIL run_clr_with_hs: got %b/%0d want 1/8", run_valid4, run_data4); end
        v = '{8'd1, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        run_one4(v, 1'b1, d, i, m, lat); @(posedge clk); #1;
        n_tests++; if (run_data4 !== 8'd1) begin n_fail++; $display("[TB] FAIL run_mode_restart: got %0d want 1", run_data4); end
    endtask

    initial begin
        in_valid4 = 1'b0; in_mode4 = 1'b0; run_clr4 = 1'b0; out_ready4 = 1'b1; in_data4 = '0;
        in_valid5 = 1'b0; in_mode5 = 1'b0; run_clr5 = 1'b0; out_ready5 = 1'b1; in_data5 = '0;
        test_reset();
        test_min_tie();
        test_max_signed();
        test_odd_lane();
        test_back_to_back();
        test_running();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
